// File: rtl/axi_slave_mem_model.sv
// AXI4 slave memory model with independent write/read FSMs and programmable latency.
// Optional define MEM_SLAVE_OOR_RESP_EN: beats addressing above the memory depth get DECERR.
module axi_slave_mem_model #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int MEM_DEPTH_LOG2 = 12,
    parameter int WR_LATENCY     = 16,
    parameter int RD_LATENCY     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     MEM_SLAVE_WR_ADDR_ID,
    input  logic [ADDR_WIDTH-1:0]   MEM_SLAVE_WR_ADDR,
    input  logic [7:0]              MEM_SLAVE_WR_ADDR_LEN,
    input  logic [1:0]              MEM_SLAVE_WR_ADDR_BURST,
    input  logic                    MEM_SLAVE_WR_ADDR_VALID,
    output logic                    MEM_SLAVE_WR_ADDR_READY,
    input  logic [DATA_WIDTH-1:0]   MEM_SLAVE_WR_DATA,
    input  logic [DATA_WIDTH/8-1:0] MEM_SLAVE_WR_STRB,
    input  logic                    MEM_SLAVE_WR_DATA_LAST,
    input  logic                    MEM_SLAVE_WR_DATA_VALID,
    output logic                    MEM_SLAVE_WR_DATA_READY,
    output logic [ID_WIDTH-1:0]     MEM_SLAVE_WR_BACK_ID,
    output logic [1:0]              MEM_SLAVE_WR_BACK_RESP,
    output logic                    MEM_SLAVE_WR_BACK_VALID,
    input  logic                    MEM_SLAVE_WR_BACK_READY,
    input  logic [ID_WIDTH-1:0]     MEM_SLAVE_RD_ADDR_ID,
    input  logic [ADDR_WIDTH-1:0]   MEM_SLAVE_RD_ADDR,
    input  logic [7:0]              MEM_SLAVE_RD_ADDR_LEN,
    input  logic [1:0]              MEM_SLAVE_RD_ADDR_BURST,
    input  logic                    MEM_SLAVE_RD_ADDR_VALID,
    output logic                    MEM_SLAVE_RD_ADDR_READY,
    output logic [ID_WIDTH-1:0]     MEM_SLAVE_RD_BACK_ID,
    output logic [DATA_WIDTH-1:0]   MEM_SLAVE_RD_DATA,
    output logic [1:0]              MEM_SLAVE_RD_DATA_RESP,
    output logic                    MEM_SLAVE_RD_DATA_LAST,
    output logic                    MEM_SLAVE_RD_DATA_VALID,
    input  logic                    MEM_SLAVE_RD_DATA_READY
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int BSHIFT = $clog2(STRB_W);
    localparam int WA_W   = ADDR_WIDTH - BSHIFT;
    localparam int DEPTH  = 1 << MEM_DEPTH_LOG2;
    localparam int CNT_W  = 16;

    localparam logic [CNT_W-1:0] WR_LAT_M1 = CNT_W'((WR_LATENCY > 0) ? WR_LATENCY - 1 : 0);
    localparam logic [CNT_W-1:0] RD_LAT_M1 = CNT_W'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);

`ifdef MEM_SLAVE_OOR_RESP_EN
    localparam bit OOR_EN = 1'b1;
`else
    localparam bit OOR_EN = 1'b0;
`endif

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_WAIT = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;
    localparam logic [1:0] W_RESP = 2'd3;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    // WRAP only for legal lengths; reserved and odd-length WRAP fall through to INCR.
    function automatic logic [WA_W-1:0] next_word(input logic [WA_W-1:0] cur,
                                                  input logic [7:0]      len,
                                                  input logic [1:0]      burst);
        logic [WA_W-1:0] inc;
        logic [WA_W-1:0] mask;
        inc  = cur + WA_W'(1);
        mask = WA_W'(len);
        if (burst == BURST_FIXED)
            next_word = cur;
        else if (burst == BURST_WRAP &&
                 (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            next_word = (cur & ~mask) | (inc & mask);
        else
            next_word = inc;
    endfunction

    function automatic logic out_of_range(input logic [WA_W-1:0] w);
        return OOR_EN && ((w >> MEM_DEPTH_LOG2) != '0);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  ready_en;
    logic                  unused_addr_bits;

    logic [1:0]            w_state;
    logic [ID_WIDTH-1:0]   w_id;
    logic [WA_W-1:0]       w_word;
    logic [7:0]            w_len;
    logic [1:0]            w_burst;
    logic [CNT_W-1:0]      w_cnt;
    logic [8:0]            w_beats;
    logic                  w_oor;
    logic [1:0]            w_resp;
    logic                  aw_hs;
    logic                  w_beat;
    logic                  beat_oor;
    logic                  count_ok;

    logic [1:0]            r_state;
    logic [ID_WIDTH-1:0]   r_id;
    logic [WA_W-1:0]       r_word;
    logic [7:0]            r_len;
    logic [1:0]            r_burst;
    logic [CNT_W-1:0]      r_cnt;
    logic [7:0]            r_beat;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  ar_hs;
    logic [WA_W-1:0]       r_nxt;
    logic                  r_load;
    logic [WA_W-1:0]       r_load_word;
    logic [1:0]            r_load_burst;

    assign unused_addr_bits = ^{MEM_SLAVE_WR_ADDR[BSHIFT-1:0], MEM_SLAVE_RD_ADDR[BSHIFT-1:0]};

    // Valid/ready: a transfer happens on a rising edge where both are high; the slave
    // never drops a valid it has raised until the matching ready is seen.
    assign MEM_SLAVE_WR_ADDR_READY = ready_en && (w_state == W_IDLE);
    assign MEM_SLAVE_WR_DATA_READY = (w_state == W_DATA);
    assign MEM_SLAVE_WR_BACK_VALID = (w_state == W_RESP);
    assign MEM_SLAVE_WR_BACK_ID    = w_id;
    assign MEM_SLAVE_WR_BACK_RESP  = w_resp;

    assign aw_hs    = MEM_SLAVE_WR_ADDR_READY && MEM_SLAVE_WR_ADDR_VALID;
    assign w_beat   = (w_state == W_DATA) && MEM_SLAVE_WR_DATA_VALID;
    assign beat_oor = out_of_range(w_word);
    assign count_ok = (w_beats == {1'b0, w_len});

    // Address readies stay low while in reset and for the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ready_en <= 1'b0;
        else     ready_en <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_word  <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_beats <= '0;
            w_oor   <= 1'b0;
            w_resp  <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        w_id    <= MEM_SLAVE_WR_ADDR_ID;
                        w_word  <= MEM_SLAVE_WR_ADDR[ADDR_WIDTH-1:BSHIFT];
                        w_len   <= MEM_SLAVE_WR_ADDR_LEN;
                        w_burst <= MEM_SLAVE_WR_ADDR_BURST;
                        w_cnt   <= '0;
                        w_beats <= '0;
                        w_oor   <= 1'b0;
                        w_state <= (WR_LATENCY == 0) ? W_DATA : W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (w_cnt == WR_LAT_M1) w_state <= W_DATA;
                    else                    w_cnt   <= w_cnt + CNT_W'(1);
                end
                W_DATA: begin
                    if (MEM_SLAVE_WR_DATA_VALID) begin
                        w_word <= next_word(w_word, w_len, w_burst);
                        if (w_beats != 9'h1FF) w_beats <= w_beats + 9'd1;
                        if (beat_oor) w_oor <= 1'b1;
                        if (MEM_SLAVE_WR_DATA_LAST) begin
                            if (w_oor || beat_oor)
                                w_resp <= RESP_DECERR;
                            else if (!count_ok || w_burst == BURST_RSVD)
                                w_resp <= RESP_SLVERR;
                            else
                                w_resp <= RESP_OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (MEM_SLAVE_WR_BACK_READY) w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset so reset mid-burst keeps already written beats.
    always_ff @(posedge clk) begin
        if (w_beat && !beat_oor) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (MEM_SLAVE_WR_STRB[b])
                    mem[w_word[MEM_DEPTH_LOG2-1:0]][b*8 +: 8] <= MEM_SLAVE_WR_DATA[b*8 +: 8];
            end
        end
    end

    assign MEM_SLAVE_RD_ADDR_READY = ready_en && (r_state == R_IDLE);
    assign MEM_SLAVE_RD_DATA_VALID = (r_state == R_DATA);
    assign MEM_SLAVE_RD_DATA_LAST  = (r_state == R_DATA) && (r_beat == r_len);
    assign MEM_SLAVE_RD_BACK_ID    = r_id;
    assign MEM_SLAVE_RD_DATA       = r_data;
    assign MEM_SLAVE_RD_DATA_RESP  = r_resp;

    assign ar_hs = MEM_SLAVE_RD_ADDR_READY && MEM_SLAVE_RD_ADDR_VALID;
    assign r_nxt = next_word(r_word, r_len, r_burst);

    // Pick which word feeds the read data register on this edge: the first beat when
    // the wait expires, or the following beat on each accepted beat.
    always_comb begin
        r_load       = 1'b0;
        r_load_word  = r_word;
        r_load_burst = r_burst;
        case (r_state)
            R_IDLE: begin
                if (ar_hs && RD_LATENCY == 0) begin
                    r_load       = 1'b1;
                    r_load_word  = MEM_SLAVE_RD_ADDR[ADDR_WIDTH-1:BSHIFT];
                    r_load_burst = MEM_SLAVE_RD_ADDR_BURST;
                end
            end
            R_WAIT: begin
                if (r_cnt == RD_LAT_M1) r_load = 1'b1;
            end
            R_DATA: begin
                if (MEM_SLAVE_RD_DATA_READY && r_beat != r_len) begin
                    r_load      = 1'b1;
                    r_load_word = r_nxt;
                end
            end
            default: ;
        endcase
    end

    // Reading mem with a non-blocking update returns pre-write data on a same-word collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_resp <= RESP_OKAY;
        end else if (r_load) begin
            if (out_of_range(r_load_word)) begin
                r_data <= '0;
                r_resp <= RESP_DECERR;
            end else begin
                r_data <= mem[r_load_word[MEM_DEPTH_LOG2-1:0]];
                r_resp <= (r_load_burst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_word  <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_beat  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_id    <= MEM_SLAVE_RD_ADDR_ID;
                        r_word  <= MEM_SLAVE_RD_ADDR[ADDR_WIDTH-1:BSHIFT];
                        r_len   <= MEM_SLAVE_RD_ADDR_LEN;
                        r_burst <= MEM_SLAVE_RD_ADDR_BURST;
                        r_cnt   <= '0;
                        r_beat  <= '0;
                        r_state <= (RD_LATENCY == 0) ? R_DATA : R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_cnt == RD_LAT_M1) r_state <= R_DATA;
                    else                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                R_DATA: begin
                    if (MEM_SLAVE_RD_DATA_READY) begin
                        if (r_beat == r_len) begin
                            r_state <= R_IDLE;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                            r_word <= r_nxt;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slave_mem_model.sv
// Directed plus randomized bench for axi_slave_mem_model against a word-array reference model.
module tb_axi_slave_mem_model;

    localparam int DW    = 32;
    localparam int IW    = 4;
    localparam int DL2   = 12;
    localparam int WL    = 16;
    localparam int RL    = 8;
    localparam int DEPTH = 1 << DL2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic [IW-1:0] aw_id    = '0;
    logic [31:0]   aw_addr  = '0;
    logic [7:0]    aw_len   = '0;
    logic [1:0]    aw_burst = '0;
    logic          aw_valid = 1'b0;
    logic          aw_ready;
    logic [31:0]   w_data   = '0;
    logic [3:0]    w_strb   = '0;
    logic          w_last   = 1'b0;
    logic          w_valid  = 1'b0;
    logic          w_ready;
    logic [IW-1:0] b_id;
    logic [1:0]    b_resp;
    logic          b_valid;
    logic          b_ready  = 1'b0;
    logic [IW-1:0] ar_id    = '0;
    logic [31:0]   ar_addr  = '0;
    logic [7:0]    ar_len   = '0;
    logic [1:0]    ar_burst = '0;
    logic          ar_valid = 1'b0;
    logic          ar_ready;
    logic [IW-1:0] r_id;
    logic [31:0]   r_data;
    logic [1:0]    r_resp;
    logic          r_last;
    logic          r_valid;
    logic          r_ready  = 1'b0;

    logic [49:0]   outs;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    logic [31:0]   ref_mem   [DEPTH];
    logic [3:0]    ref_known [DEPTH];
    logic [31:0]   wdata_a   [256];
    logic [3:0]    wstrb_a   [256];

    axi_slave_mem_model #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(32), .ID_WIDTH(IW), .MEM_DEPTH_LOG2(DL2),
        .WR_LATENCY(WL), .RD_LATENCY(RL)
    ) dut (
        .clk(clk), .rst(rst),
        .MEM_SLAVE_WR_ADDR_ID(aw_id), .MEM_SLAVE_WR_ADDR(aw_addr),
        .MEM_SLAVE_WR_ADDR_LEN(aw_len), .MEM_SLAVE_WR_ADDR_BURST(aw_burst),
        .MEM_SLAVE_WR_ADDR_VALID(aw_valid), .MEM_SLAVE_WR_ADDR_READY(aw_ready),
        .MEM_SLAVE_WR_DATA(w_data), .MEM_SLAVE_WR_STRB(w_strb),
        .MEM_SLAVE_WR_DATA_LAST(w_last), .MEM_SLAVE_WR_DATA_VALID(w_valid),
        .MEM_SLAVE_WR_DATA_READY(w_ready),
        .MEM_SLAVE_WR_BACK_ID(b_id), .MEM_SLAVE_WR_BACK_RESP(b_resp),
        .MEM_SLAVE_WR_BACK_VALID(b_valid), .MEM_SLAVE_WR_BACK_READY(b_ready),
        .MEM_SLAVE_RD_ADDR_ID(ar_id), .MEM_SLAVE_RD_ADDR(ar_addr),
        .MEM_SLAVE_RD_ADDR_LEN(ar_len), .MEM_SLAVE_RD_ADDR_BURST(ar_burst),
        .MEM_SLAVE_RD_ADDR_VALID(ar_valid), .MEM_SLAVE_RD_ADDR_READY(ar_ready),
        .MEM_SLAVE_RD_BACK_ID(r_id), .MEM_SLAVE_RD_DATA(r_data),
        .MEM_SLAVE_RD_DATA_RESP(r_resp), .MEM_SLAVE_RD_DATA_LAST(r_last),
        .MEM_SLAVE_RD_DATA_VALID(r_valid), .MEM_SLAVE_RD_DATA_READY(r_ready)
    );

    assign outs = {aw_ready, w_ready, b_id, b_resp, b_valid, ar_ready,
                   r_id, r_data, r_resp, r_last, r_valid};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word visited on beat i of a burst, from the burst rules alone.
    function automatic int beat_word(input int start, input int len, input int burst, input int i);
        int span;
        if (burst == 0) return start % DEPTH;
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            span = len + 1;
            return (start / span) * span + ((start % span) + i) % span;
        end
        return (start + i) % DEPTH;
    endfunction

    function automatic logic [31:0] known_mask(input int w);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = ref_known[w][b] ? 8'hFF : 8'h00;
        return m;
    endfunction

    task automatic do_write(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                            input int burst, input int nbeats, input int stop_after,
                            output logic [1:0] resp, output logic [IW-1:0] bid,
                            output int wr_lat, output int b_lat);
        int hs, g, first, w, sent;
        resp = 'x; bid = 'x; wr_lat = -1; b_lat = -1; first = -1;
        @(negedge clk);
        aw_id = id; aw_addr = addr; aw_len = 8'(len); aw_burst = 2'(burst); aw_valid = 1'b1;
        g = 0;
        while (!aw_ready && g < 1000) begin @(negedge clk); g++; end
        check("aw_ready_wait", aw_ready, 1);
        @(negedge clk);
        aw_valid = 1'b0;
        hs = cyc;
        sent = (stop_after >= 0) ? stop_after : nbeats;
        for (int i = 0; i < sent; i++) begin
            w_data = wdata_a[i]; w_strb = wstrb_a[i]; w_last = (i == nbeats - 1); w_valid = 1'b1;
            g = 0;
            while (!w_ready && g < 1000) begin @(negedge clk); g++; end
            check("w_ready_wait", w_ready, 1);
            if (first < 0) first = cyc;
            w = beat_word(int'(addr >> 2), len, burst, i);
            for (int b = 0; b < 4; b++) begin
                if (wstrb_a[i][b]) begin
                    ref_mem[w][b*8 +: 8] = wdata_a[i][b*8 +: 8];
                    ref_known[w][b] = 1'b1;
                end
            end
            @(negedge clk);
        end
        w_valid = 1'b0; w_last = 1'b0;
        if (stop_after >= 0) return;
        wr_lat = first - hs;
        g = 0;
        while (!b_valid && g < 1000) begin @(negedge clk); g++; end
        check("b_valid_wait", b_valid, 1);
        b_lat = cyc - hs;
        resp = b_resp; bid = b_id;
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check("b_valid_hold", b_valid, 1);
        end
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        check("aw_ready_after_b", {aw_ready, b_valid}, 2'b10);
    endtask

    task automatic do_read(input logic [IW-1:0] id, input int word, input int len, input int burst,
                           input bit toggle, output logic [31:0] first_data, output bit saw_last_low);
        int hs, g, beat, w;
        bit tog;
        logic [31:0] m;
        first_data = 'x; saw_last_low = 1'b0; tog = 1'b0;
        @(negedge clk);
        ar_id = id; ar_addr = 32'(word) << 2; ar_len = 8'(len); ar_burst = 2'(burst); ar_valid = 1'b1;
        g = 0;
        while (!ar_ready && g < 1000) begin @(negedge clk); g++; end
        check("ar_ready_wait", ar_ready, 1);
        @(negedge clk);
        ar_valid = 1'b0;
        hs = cyc;
        g = 0;
        while (!r_valid && g < 1000) begin @(negedge clk); g++; end
        check("r_valid_wait", r_valid, 1);
        check("rd_latency", cyc - hs, RL);
        beat = 0; g = 0;
        while (beat <= len && g < 4000) begin
            g++;
            if (r_valid) begin
                w = beat_word(word, len, burst, beat);
                m = known_mask(w);
                check("r_data", r_data & m, ref_mem[w] & m);
                check("r_resp", r_resp, (burst == 3) ? 2'b10 : 2'b00);
                check("r_last", r_last, beat == len);
                check("r_id", r_id, id);
                if (toggle) begin r_ready = tog; tog = !tog; end
                else        r_ready = 1'($urandom_range(0, 1));
                if (r_ready) begin
                    if (beat == 0) first_data = r_data;
                    beat++;
                end else if (r_last) begin
                    saw_last_low = 1'b1;
                end
            end else begin
                check("r_valid_held", r_valid, 1);
                r_ready = 1'b0;
            end
            @(negedge clk);
        end
        r_ready = 1'b0;
        check("r_beats", beat, len + 1);
        check("r_idle_after", {r_valid, ar_ready}, 2'b01);
    endtask

    initial begin
        logic [1:0]    resp;
        logic [IW-1:0] bid;
        int            wl, bl, len, burst, word;
        logic [31:0]   fd;
        bit            sll;
        logic [IW-1:0] id;
        int            lens [6];

        lens = '{0, 1, 3, 7, 15, 5};
        for (int i = 0; i < DEPTH; i++) ref_known[i] = '0;

        // Reset: outputs low, address readies rise only after the first clock.
        #2;
        check("reset_outputs", outs, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_before_clk", {aw_ready, ar_ready}, 2'b00);
        @(negedge clk);
        check("ready_after_reset", {aw_ready, ar_ready}, 2'b11);

        // INCR burst at 0x100 with fixed latency and full strobes.
        for (int i = 0; i < 4; i++) begin wdata_a[i] = 32'hA0 + i; wstrb_a[i] = 4'hF; end
        do_write(4'h3, 32'h100, 3, 1, 4, -1, resp, bid, wl, bl);
        check("t1_bresp", resp, 2'b00);
        check("t1_bid", bid, 4'h3);
        check("t1_wready_latency", wl, WL);
        check("t1_bvalid_latency", bl, WL + 4);
        do_read(4'h5, 'h40, 3, 1, 1'b0, fd, sll);
        check("t1_first_beat", fd, 32'hA0);

        // Byte strobes merge into the existing word.
        wdata_a[0] = 32'h11223344; wstrb_a[0] = 4'hF;
        do_write(4'h1, 32'h100, 0, 1, 1, -1, resp, bid, wl, bl);
        check("strb_full_bresp", resp, 2'b00);
        wdata_a[0] = 32'hFFFFFFFF; wstrb_a[0] = 4'b0101;
        do_write(4'h1, 32'h100, 0, 1, 1, -1, resp, bid, wl, bl);
        check("strb_part_bresp", resp, 2'b00);
        do_read(4'h2, 'h40, 0, 1, 1'b0, fd, sll);
        check("strb_merge", fd, 32'h11FF33FF);

        // WRAP read from word 6 of the aligned 4-word block.
        for (int i = 0; i < 4; i++) begin wdata_a[i] = 32'hB4 + i; wstrb_a[i] = 4'hF; end
        do_write(4'h6, 32'h10, 3, 1, 4, -1, resp, bid, wl, bl);
        check("wrap_fill_bresp", resp, 2'b00);
        do_read(4'h7, 6, 3, 2, 1'b0, fd, sll);
        check("wrap_first_word6", fd, 32'hB6);

        // Alternating RREADY: every beat stalls once, including the last.
        for (int i = 0; i < 8; i++) begin wdata_a[i] = $urandom(); wstrb_a[i] = 4'hF; end
        do_write(4'h8, 32'h300, 7, 1, 8, -1, resp, bid, wl, bl);
        check("toggle_fill_bresp", resp, 2'b00);
        do_read(4'h8, 'hC0, 7, 1, 1'b1, fd, sll);
        check("last_with_ready_low", sll, 1'b1);

        // Early WLAST gives SLVERR, and the next write is clean.
        for (int i = 0; i < 4; i++) begin wdata_a[i] = 32'hE0 + i; wstrb_a[i] = 4'hF; end
        do_write(4'h9, 32'h400, 3, 1, 3, -1, resp, bid, wl, bl);
        check("early_last_bresp", resp, 2'b10);
        check("early_last_bid", bid, 4'h9);
        do_write(4'hA, 32'h400, 3, 1, 4, -1, resp, bid, wl, bl);
        check("after_err_bresp", resp, 2'b00);
        check("after_err_bid", bid, 4'hA);

        // Reset after two accepted beats keeps those beats in memory.
        for (int i = 0; i < 4; i++) begin wdata_a[i] = 32'hD0 + i; wstrb_a[i] = 4'hF; end
        do_write(4'hB, 32'h200, 3, 1, 4, 2, resp, bid, wl, bl);
        rst = 1'b1;
        #1;
        check("midburst_reset_outputs", outs, '0);
        repeat (2) @(negedge clk);
        check("reset_held_outputs", outs, '0);
        rst = 1'b0;
        #1;
        check("ready_before_clk2", {aw_ready, ar_ready}, 2'b00);
        @(negedge clk);
        check("ready_after_reset2", {aw_ready, ar_ready}, 2'b11);
        do_read(4'hC, 'h80, 1, 1, 1'b0, fd, sll);
        check("kept_beat0", fd, 32'hD0);

        // Randomized bursts of every type, including wrap-around at the top of memory.
        for (int t = 0; t < 10; t++) begin
            id    = IW'($urandom_range(0, 15));
            burst = $urandom_range(0, 3);
            len   = ($urandom_range(0, 1) == 1) ? lens[$urandom_range(0, 5)] : $urandom_range(0, 20);
            word  = $urandom_range(0, DEPTH - 1);
            for (int i = 0; i <= len; i++) begin
                wdata_a[i] = $urandom();
                wstrb_a[i] = 4'($urandom_range(0, 15));
            end
            do_write(id, 32'(word) << 2, len, burst, len + 1, -1, resp, bid, wl, bl);
            check("rand_bresp", resp, (burst == 3) ? 2'b10 : 2'b00);
            check("rand_bid", bid, id);
            check("rand_wready_latency", wl, WL);
            do_read(~id, word, len, burst, 1'b0, fd, sll);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
